// File: rtl/vectored_interrupt_controller.sv
// Fixed-priority vectored interrupt controller with mepc/mcause capture.
// Sits between the pipeline's PC-next mux and the PC register.
module vectored_interrupt_controller #(
    parameter int NUM_SRC   = 8,
    parameter int PC_W      = 32,
    parameter bit EDGE_TRIG = 1'b1,
    parameter bit VECTORED  = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] irq,
    input  logic [NUM_SRC-1:0] irq_en,
    input  logic               global_ie,
    input  logic [PC_W-1:0]    mtvec_base,
    input  logic [PC_W-1:0]    pc_next,
    input  logic               mret,
    output logic [PC_W-1:0]    pc_next_final,
    output logic [PC_W-1:0]    mepc,
    output logic [4:0]         mcause,
    output logic               irq_ack,
    output logic               in_isr,
    output logic [NUM_SRC-1:0] pending
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SAVE   = 2'd1;
    localparam logic [1:0] S_VECTOR = 2'd2;
    localparam logic [1:0] S_ISR    = 2'd3;

    logic [1:0]         state_q;
    logic [1:0]         state_d;
    logic [NUM_SRC-1:0] eligible;
    logic [4:0]         winner;
    logic               claim;
    logic [PC_W-1:0]    base_aligned;
    logic [PC_W-1:0]    vec_off;

    assign eligible = pending & irq_en & {NUM_SRC{global_ie}};
    assign claim    = (state_q == S_IDLE) && (|eligible);

    // Scan downward so the lowest set index wins.
    always_comb begin
        winner = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                winner = 5'(i);
            end
        end
    end

    if (EDGE_TRIG) begin : g_edge
        logic [NUM_SRC-1:0] irq_d;
        logic [NUM_SRC-1:0] pend_q;
        logic [NUM_SRC-1:0] claim_mask;

        assign claim_mask = claim ? (NUM_SRC'(1) << winner) : '0;

        // A fresh edge in the claim cycle re-arms the bit.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                irq_d  <= '0;
                pend_q <= '0;
            end else begin
                irq_d  <= irq;
                pend_q <= (pend_q & ~claim_mask) | (irq & ~irq_d);
            end
        end

        assign pending = pend_q;
    end else begin : g_level
        assign pending = irq;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (claim) state_d = S_SAVE;
            S_SAVE:   state_d = S_VECTOR;
            S_VECTOR: state_d = S_ISR;
            S_ISR:    if (mret) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            mepc    <= '0;
            mcause  <= '0;
        end else begin
            state_q <= state_d;
            if (claim) begin
                mcause <= winner;
            end
            if (state_q == S_SAVE) begin
                mepc <= pc_next;
            end
        end
    end

    assign base_aligned = mtvec_base & ~PC_W'(3);

    always_comb begin
        vec_off = '0;
        if (VECTORED) begin
            vec_off = PC_W'(mcause) << 2;
        end
    end

    always_comb begin
        pc_next_final = pc_next;
        if (state_q == S_VECTOR) begin
            pc_next_final = base_aligned + vec_off;
        end else if (state_q == S_ISR && mret) begin
            pc_next_final = mepc;
        end
    end

    assign irq_ack = (state_q == S_VECTOR);
    assign in_isr  = (state_q != S_IDLE);

endmodule

// File: doc/vectored_interrupt_controller.md
Name: vectored_interrupt_controller

Overview:
Parametrised successor to the single-line interrupt controller. Arbitrates NUM_SRC interrupt sources by fixed priority and saves the interrupted PC into an internal mepc register. Records the claimed source in mcause and steers the PC to a direct or vectored trap handler; on mret it restores the saved PC. Sits between the PC-next logic and the PC register of the CPU pipeline. Non-nesting.

Parameters:
NUM_SRC, 8, number of interrupt sources (1..32); index 0 has the highest priority.
PC_W, 32, PC and trap-vector width.
EDGE_TRIG, 1, 1 = sources are rising-edge latched into pending; 0 = level (pending = irq).
VECTORED, 1, 1 = handler target is base + 4*id; 0 = all sources jump to base.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
reset  in  1  asynchronous, active-low reset.
irq  in  NUM_SRC  interrupt request lines, synchronous to clk.
irq_en  in  NUM_SRC  per-source enable mask.
global_ie  in  1  global interrupt enable.
mtvec_base  in  PC_W  trap base address; bits [1:0] are ignored.
pc_next  in  PC_W  PC-next value from the pipeline.
mret  in  1  one-cycle pulse: the ISR return instruction is executing.
pc_next_final  out  PC_W  PC-next value selected for the PC register.
mepc  out  PC_W  saved return PC.
mcause  out  5  id of the claimed source.
irq_ack  out  1  one-cycle pulse in the VECTOR state.
in_isr  out  1  high in the SAVE, VECTOR and ISR states.
pending  out  NUM_SRC  pending vector.

Behaviour:
- Reset (reset=0, asynchronous) forces the following, regardless of the clock:
  - state = IDLE; pending = 0; mepc = 0; mcause = 0; irq_ack = 0; in_isr = 0.
  - pc_next_final follows pc_next.
- Pending:
  - EDGE_TRIG=1: pending[i] is set when irq[i] is 1 in this cycle and was 0 in the previous cycle (irq_d register, reset to 0).
  - EDGE_TRIG=1: pending[i] is cleared on the cycle the source is claimed. A set and a clear in the same cycle resolve to set.
  - EDGE_TRIG=0: pending = irq (combinational).
- Eligibility: eligible = pending & irq_en & {NUM_SRC{global_ie}}. The winner is the lowest set index, with a 5-bit id.
- FSM state IDLE:
  - pc_next_final = pc_next.
  - If eligible is non-zero: latch mcause = winner, clear the claimed pending bit (edge mode), then go to SAVE.
  - Otherwise remain in IDLE.
- FSM state SAVE:
  - pc_next_final = pc_next.
  - mepc is loaded with pc_next on exit, then go to VECTOR.
  - The state is committed even if irq, irq_en or global_ie drop during SAVE.
- FSM state VECTOR:
  - pc_next_final = {mtvec_base[PC_W-1:2],2'b00}, plus (mcause<<2) when VECTORED=1.
  - The addition wraps modulo 2^PC_W.
  - irq_ack = 1; go to ISR.
- FSM state ISR:
  - pc_next_final = pc_next while mret=0.
  - When mret=1: pc_next_final = mepc in the same cycle (combinational), and the next state is IDLE.
- Timing: interrupt decision to handler PC is 2 cycles (IDLE→SAVE→VECTOR). After mret, the earliest next claim is from IDLE on the following cycle, so there is at least one IDLE cycle between ISRs.
- mret outside the ISR state is ignored; pc_next_final passes through.
- New requests arriving during SAVE, VECTOR or ISR accumulate in pending (edge mode) and are not claimed until IDLE. No nesting.
- If mret and a new eligible request occur in the same ISR cycle, the return takes effect first and the request is claimed from IDLE on the next cycle.
- Reset asserted mid-ISR aborts the ISR; mepc and pending are lost.
- mepc and mcause hold their values until the next claim.

Test Plan:
- Reset then idle: reset=0 for 2 cycles, release, no irq → state IDLE, pending=0, mepc=0, pc_next_final==pc_next each cycle.
- Single vectored IRQ: irq_en=8'hFF, global_ie=1, mtvec_base=32'h100, pc_next=32'h40, pulse irq[3] → mcause=3 one cycle later, mepc=32'h40 after SAVE, pc_next_final=32'h10C with irq_ack=1 two cycles after the claim, pending[3]=0.
- Priority and deferral: assert irq[5] and irq[2] in the same cycle → claim 2. Assert mret in ISR with mepc=32'h40 → pc_next_final=32'h40 that cycle. One IDLE cycle later, claim 5 → handler 32'h114.
- Masking: irq_en[1]=0, edge on irq[1] → pending[1]=1, no claim. Set irq_en[1]=1 → claim, mcause=1. Repeat with global_ie=0 → no claim.
- Direct mode and wrap: VECTORED=0, mtvec_base=32'hFFFF_FFF3, irq[7] → handler 32'hFFFF_FFF0. VECTORED=1 with the same base → 32'h0000_000C (wrap).
- Async reset mid-ISR: enter ISR, drop reset between clock edges → outputs clear immediately, in_isr=0, and a subsequent mret causes no redirect.
